// File: rtl/conv_post_proc_pkg.sv
// Shared definitions for the conv post-MAC stage: activation modes, window size
// and the clamp helper used for both accumulator and output saturation.
package conv_post_proc_pkg;

  localparam int PIX         = 4;
  localparam int LEAKY_SHIFT = 3;

  typedef enum logic [1:0] {
    MODE_LIN   = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_RSVD  = 2'd3
  } modeT;

  function automatic logic signed [63:0] satClamp(input logic signed [63:0] x,
                                                  input logic signed [63:0] lo,
                                                  input logic signed [63:0] hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_post_proc_if.sv
// Beat bus between mac_bank and the post-processing stage, plus its result side.
interface conv_post_proc_if #(
  parameter int NUM_FILT = 4,
  parameter int NUM_PART = 3,
  parameter int PSUM_W   = 20,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5
);
  import conv_post_proc_pkg::*;

  logic                                   i_vld;
  logic                                   i_first;
  logic                                   i_last;
  logic [NUM_FILT*NUM_PART*PIX*PSUM_W-1:0] i_psum;
  logic [NUM_FILT*BIAS_W-1:0]             i_bias;
  logic [SHIFT_W-1:0]                     i_shift;
  logic [1:0]                             i_mode;
  logic                                   i_pool_en;
  logic                                   o_vld;
  logic [NUM_FILT*PIX*OUT_W-1:0]          o_data;
  logic                                   o_ovf;

  modport master (
    output i_vld, i_first, i_last, i_psum, i_bias, i_shift, i_mode, i_pool_en,
    input  o_vld, o_data, o_ovf
  );

  modport slave (
    input  i_vld, i_first, i_last, i_psum, i_bias, i_shift, i_mode, i_pool_en,
    output o_vld, o_data, o_ovf
  );

endinterface

// File: rtl/conv_post_proc_lane.sv
// One filter x one pixel: partial-sum reduce, pass accumulation, bias,
// rounding requantise, activation and output saturation (S1..S4).
module conv_post_proc_lane
  import conv_post_proc_pkg::*;
#(
  parameter int NUM_PART = 3,
  parameter int PSUM_W   = 20,
  parameter int ACC_W    = 32,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inVld,
  input  logic [NUM_PART*PSUM_W-1:0] psum,
  input  logic                       s1Vld,
  input  logic                       s1First,
  input  logic                       s2Vld,
  input  logic                       s3Vld,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic [SHIFT_W-1:0]         shift,
  input  modeT                       mode,
  output logic                       ovfHit,
  output logic signed [OUT_W-1:0]    res
);

  localparam int V_W = ACC_W + 1;
  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OUT_W - 1));

  logic signed [ACC_W-1:0] sumNext, sumQ, accQ;
  logic signed [V_W-1:0]   vQ;
  logic signed [63:0]      accSum, vWide, rnd, act;

  always_comb begin
    sumNext = '0;
    for (int p = 0; p < NUM_PART; p++)
      sumNext = sumNext + ACC_W'($signed(psum[p*PSUM_W +: PSUM_W]));
    accSum = 64'(accQ) + 64'(sumQ);
    ovfHit = s1Vld && !s1First && (accSum > ACC_MAX || accSum < ACC_MIN);
  end

  // Round half up before the arithmetic shift; shift 0 is a straight pass.
  always_comb begin
    vWide = 64'(vQ);
    rnd   = (shift == '0) ? vWide : (vWide + (64'sd1 <<< (shift - 1'b1))) >>> shift;
    case (mode)
      MODE_RELU:  act = rnd[63] ? '0 : rnd;
      MODE_LEAKY: act = rnd[63] ? (rnd >>> LEAKY_SHIFT) : rnd;
      default:    act = rnd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sumQ <= '0;
      accQ <= '0;
      vQ   <= '0;
      res  <= '0;
    end else begin
      if (inVld) sumQ <= sumNext;
      if (s1Vld) accQ <= s1First ? sumQ : ACC_W'(satClamp(accSum, ACC_MIN, ACC_MAX));
      if (s2Vld) vQ <= V_W'(accQ) + V_W'(bias);
      if (s3Vld) res <= OUT_W'(satClamp(act, OUT_MIN, OUT_MAX));
    end
  end

endmodule

// File: rtl/conv_post_proc.sv
// Post-MAC stage: per-lane arithmetic in conv_post_proc_lane, config pipe that
// follows the last beat of each window, and the optional 2x2 max-pool (S5).
module conv_post_proc
  import conv_post_proc_pkg::*;
#(
  parameter int NUM_FILT = 4,
  parameter int NUM_PART = 3,
  parameter int PSUM_W   = 20,
  parameter int ACC_W    = 32,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  conv_post_proc_if.slave  bus
);

  localparam int LANES = NUM_FILT * PIX;

  logic                       s1Vld, s1First, s1Last, s2Vld, s3Vld, s4Vld;
  logic [NUM_FILT*BIAS_W-1:0] bias1, bias2;
  logic [SHIFT_W-1:0]         shift1, shift2, shift3;
  modeT                       mode1, mode2, mode3;
  logic                       pool1, pool2, pool3, pool4;
  logic [LANES-1:0]           ovfHit;
  logic signed [OUT_W-1:0]    res [LANES];
  logic signed [OUT_W-1:0]    mx;
  logic [LANES*OUT_W-1:0]     dataNext;

  // Config is latched only on the closing beat and then rides with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Vld <= 1'b0; s1First <= 1'b0; s1Last <= 1'b0;
      s2Vld <= 1'b0; s3Vld <= 1'b0; s4Vld <= 1'b0;
      bias1 <= '0; bias2 <= '0;
      shift1 <= '0; shift2 <= '0; shift3 <= '0;
      mode1 <= MODE_LIN; mode2 <= MODE_LIN; mode3 <= MODE_LIN;
      pool1 <= 1'b0; pool2 <= 1'b0; pool3 <= 1'b0; pool4 <= 1'b0;
      bus.o_vld  <= 1'b0;
      bus.o_data <= '0;
      bus.o_ovf  <= 1'b0;
    end else begin
      s1Vld   <= bus.i_vld;
      s1First <= bus.i_vld & bus.i_first;
      s1Last  <= bus.i_vld & bus.i_last;
      if (bus.i_vld & bus.i_last) begin
        bias1  <= bus.i_bias;
        shift1 <= bus.i_shift;
        mode1  <= modeT'(bus.i_mode);
        pool1  <= bus.i_pool_en;
      end
      s2Vld <= s1Vld & s1Last;
      bias2 <= bias1; shift2 <= shift1; mode2 <= mode1; pool2 <= pool1;
      s3Vld <= s2Vld;
      shift3 <= shift2; mode3 <= mode2; pool3 <= pool2;
      s4Vld <= s3Vld;
      pool4 <= pool3;
      bus.o_vld <= s4Vld;
      if (s4Vld) bus.o_data <= dataNext;
      if (|ovfHit) bus.o_ovf <= 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    conv_post_proc_lane #(
      .NUM_PART(NUM_PART), .PSUM_W(PSUM_W), .ACC_W(ACC_W),
      .BIAS_W(BIAS_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) uLane (
      .clk    (clk),
      .rst    (rst),
      .inVld  (bus.i_vld),
      .psum   (bus.i_psum[g*NUM_PART*PSUM_W +: NUM_PART*PSUM_W]),
      .s1Vld  (s1Vld),
      .s1First(s1First),
      .s2Vld  (s2Vld),
      .s3Vld  (s3Vld),
      .bias   (bias2[(g/PIX)*BIAS_W +: BIAS_W]),
      .shift  (shift3),
      .mode   (mode3),
      .ovfHit (ovfHit[g]),
      .res    (res[g])
    );
  end

  always_comb begin
    dataNext = '0;
    mx       = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      mx = res[f*PIX];
      for (int p = 1; p < PIX; p++)
        if (res[f*PIX+p] > mx) mx = res[f*PIX+p];
      if (pool4) begin
        dataNext[f*PIX*OUT_W +: OUT_W] = mx;
      end else begin
        for (int p = 0; p < PIX; p++)
          dataNext[(f*PIX+p)*OUT_W +: OUT_W] = res[f*PIX+p];
      end
    end
  end

endmodule

// File: doc/conv_post_proc.md
Name: conv_post_proc

Overview:
- Parametrised post-MAC stage for the conv layers. Replaces the fixed 4-filter adder-tree plus additional-layer path.
- Per filter and per 2x2 output window: sums the partial sums from the MAC bank, accumulates across multiple input-channel passes, adds bias, requantises by a shift, applies the selected activation, saturates, and optionally max-pools.
- Sits between mac_bank and the next layer's buffer.

Parameters:
- NUM_FILT, 4, filters processed in parallel
- NUM_PART, 3, partial sums per filter per pixel (channel lanes)
- PSUM_W, 20, signed partial-sum width
- ACC_W, 32, signed accumulator width
- BIAS_W, 16, signed bias width
- OUT_W, 8, signed output width
- SHIFT_W, 5, requantise shift width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_vld  in  1  partial-sum beat valid
- i_first  in  1  first input-channel pass of this window (qualified by i_vld)
- i_last  in  1  last pass; triggers output (qualified by i_vld)
- i_psum  in  NUM_FILT*NUM_PART*4*PSUM_W  signed partial sums; index order [f][pix][part], pix 0..3 = 2x2 window
- i_bias  in  NUM_FILT*BIAS_W  signed bias per filter
- i_shift  in  SHIFT_W  arithmetic right shift for requantise
- i_mode  in  2  0 = linear, 1 = ReLU, 2 = leaky ReLU (neg >>> 3), 3 = reserved (treated as linear)
- i_pool_en  in  1  1 = 2x2 max-pool
- o_vld  out  1  output beat valid
- o_data  out  NUM_FILT*4*OUT_W  results [f][pix]
- o_ovf  out  1  sticky: accumulator saturated since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - o_vld = 0, o_data = 0, o_ovf = 0.
  - All accumulators and pipeline valids cleared.
  - Reset mid-operation discards in-flight beats; no o_vld is produced for them.
- S1 (reg): sum[f][p] = sum of the NUM_PART sign-extended psums, at ACC_W.
- S2 (reg), when S1 valid:
  - acc[f][p] = first ? sum : sat(acc + sum).
  - sat() clamps to the signed ACC_W range and sets o_ovf.
  - acc holds when no valid beat arrives.
- Config: i_bias, i_shift, i_mode and i_pool_en are sampled on the i_vld & i_last beat and piped alongside it. Changes on other beats have no effect.
- S3 (reg), last beats only: v = acc + sign-extended bias.
- S4 (reg):
  - If shift > 0: r = (v + (1 << (shift-1))) >>> shift (round half up). If shift = 0: r = v.
  - Activation per i_mode.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- S5 (reg):
  - pool_en = 1: lane pix0 = signed max of the 4 pixels; pix1..3 = 0.
  - pool_en = 0: all 4 pixels pass through.
  - o_vld = 1 for exactly one cycle.
- Latency: o_vld is asserted 5 cycles after the i_vld & i_last beat (beat at cycle N, o_vld at N+5). Throughput is one beat per cycle; there is no backpressure.
- i_first & i_last on the same beat: single-pass window; result = sum + bias.
- i_vld without i_first after reset: accumulates onto 0.
- A new window's i_first beat may immediately follow the previous i_last beat with no bubble. Accumulator reuse is safe because S3 captured acc.
- o_data holds its value when o_vld = 0.
- i_first / i_last are ignored when i_vld = 0.

Decomposition:
- Shared package:
  - mode encodings MODE_LIN / MODE_RELU / MODE_LEAKY
  - LEAKY_SHIFT = 3
  - pixel count PIX = 4
  - saturate function
- One sub-module is natural: pp_lane (one filter × one pixel, stages S1–S4), instantiated NUM_FILT*4 times via generate. The pooling stage stays at top level.

Test Plan:
- Single pass, linear: psums 10, 20, 30; bias 5; shift 0; i_first = i_last = 1 -> o_data = 65 on all lanes, o_vld exactly at N+5.
- Three-pass accumulate: each pass psums 100 ×3; bias 0; shift 2 -> acc 900, r = (900 + 2) >>> 2 = 225 -> saturates to 127.
- ReLU / leaky: sum −40, shift 0 -> ReLU 0; leaky −5; linear −40; sum −1000 linear -> −128.
- Pool: pixels f0 = {3, −7, 12, 9}, pool_en = 1 -> pix0 = 12, pix1..3 = 0; pool_en = 0 -> 3, −7, 12, 9.
- Back-to-back windows: beats (first, last), then (first), (last) on consecutive cycles -> two o_vld pulses at N+5 and N+7 with independent results.
- Rounding, overflow, reset:
  - shift 1, v = 3 -> 2; v = −3 -> −1.
  - psums at +2^19−1 repeated to exceed ACC_W -> clamps and o_ovf = 1.
  - rst asserted at N+2 -> no o_vld; all outputs 0.
